// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the MIPS datapath. Owns the program counter, drives the
// read address of a combinational byte-addressed instruction memory, and
// registers each fetched word together with its PC for the decode stage.
// Fetch stops at the end of the loaded program (DONE) and locks up on an
// illegal redirect (FAULT) until reset.
//
// Parameters
//   RESET_PC        PC loaded on reset.
//   PC_LIMIT        first byte address past the program; no fetch at
//                   pc >= PC_LIMIT (unsigned compare).
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   address         instruction-memory read address (== internal pc)
//   data_out        instruction-memory read data, valid in the same cycle
//   stall           decode not ready: hold pc, outputs and state
//   redirect_valid  branch/jump taken this cycle (wins over stall)
//   redirect_target new pc when redirect_valid is high (must be word aligned)
//   instr           registered instruction word
//   instr_pc        byte address instr was fetched from
//   instr_valid     instr/instr_pc hold a live instruction
//   halted          fetch stopped (DONE or FAULT)
//   fault           FAULT state reached
//
// Build option
//   IFETCH_OPCODE_CHECK_EN  when defined, each fetched word is screened
//                           before capture; only lw, sw, add and mul are
//                           accepted, anything else sends fetch to FAULT.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd360
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_DONE  = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // A redirect target is usable only if it points at a word boundary.
    function automatic logic is_aligned(input logic [31:0] target);
        logic ok;
        if (target[1:0] == 2'b00) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

`ifdef IFETCH_OPCODE_CHECK_EN
    // Screens a fetched word against the supported instruction subset:
    // lw, sw, and R-type add / mul.
    function automatic logic opcode_legal(input logic [31:0] word);
        logic ok;
        case (word[31:26])
            6'b100011: ok = 1'b1;                      // lw
            6'b101011: ok = 1'b1;                      // sw
            6'b000000: begin
                case (word[5:0])
                    6'b100000: ok = 1'b1;              // add
                    6'b011000: ok = 1'b1;              // mul
                    default:   ok = 1'b0;
                endcase
            end
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Registers and next-state values
    // -------------------------------------------------------------------------
    logic [1:0]  state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q,      halted_d;
    logic        fault_q,       fault_d;

    // Fetch qualifiers derived from the current pc / memory word.
    logic        in_range_s;
    logic        word_ok_s;

    // Unsigned 32-bit comparison against the end of the program image.
    assign in_range_s = (pc_q < PC_LIMIT);

`ifdef IFETCH_OPCODE_CHECK_EN
    assign word_ok_s = opcode_legal(data_out);
`else
    assign word_ok_s = 1'b1;
`endif

    // Next-state logic: redirect beats stall beats fetch while running.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Either way the in-flight word is discarded.
                    instr_valid_d = 1'b0;
                    if (is_aligned(redirect_target)) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (stall) begin
                    // Decode not ready: everything holds.
                    state_d = state_q;
                end else if (in_range_s) begin
                    if (word_ok_s) begin
                        instr_d       = data_out;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                    end else begin
                        // Illegal word: keep the last good instr/instr_pc.
                        instr_valid_d = 1'b0;
                        state_d       = ST_FAULT;
                    end
                end else begin
                    // Ran off the end of the program; pc parks at the limit.
                    instr_valid_d = 1'b0;
                    state_d       = ST_DONE;
                end
            end

            ST_DONE: begin
                // Only a redirect can restart fetch; stall is irrelevant here.
                instr_valid_d = 1'b0;
                if (redirect_valid) begin
                    if (is_aligned(redirect_target)) begin
                        pc_d    = redirect_target;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_FAULT: begin
                // Sticky: only reset leaves FAULT.
                instr_valid_d = 1'b0;
                state_d       = ST_FAULT;
            end

            default: begin
                // Unreachable encoding: fail safe into FAULT.
                instr_valid_d = 1'b0;
                state_d       = ST_FAULT;
            end
        endcase
    end

    // Status flags follow the next state so they register with it.
    always_comb begin
        halted_d = (state_d != ST_RUN);
        fault_d  = (state_d == ST_FAULT);
    end

    // State, pc and the decode-facing output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign address     = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch: a word-array instruction memory is
// read combinationally from address; outputs are sampled 1 time unit after
// each rising edge and inputs are changed at that same point.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_out;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:127];

    int n_checks;
    int n_pass;

    instruction_fetch #(
        .RESET_PC (32'd0),
        .PC_LIMIT (32'd360)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .data_out        (data_out),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .halted          (halted),
        .fault           (fault)
    );

    assign data_out = (address < 32'd512) ? mem[address[8:2]] : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic v, input logic h, input logic f);
        check({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, v});
        check({tag, ".halted"}, {31'd0, halted},      {31'd0, h});
        check({tag, ".fault"},  {31'd0, fault},       {31'd0, f});
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h8C000000 | i;   // lw-encoded filler words
        end
        mem[0] = 32'h8D100200;
        mem[1] = 32'h8D300300;

        // Reset state
        tick();
        tick();
        check("rst.address",  address,  32'd0);
        check("rst.instr",    instr,    32'd0);
        check("rst.instr_pc", instr_pc, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Program load: one-cycle latency, one word per cycle
        tick();
        check("load1.instr",    instr,    32'h8D100200);
        check("load1.instr_pc", instr_pc, 32'd0);
        check_status("load1", 1'b1, 1'b0, 1'b0);
        check("load1.address",  address,  32'd4);
        tick();
        check("load2.instr",    instr,    32'h8D300300);
        check("load2.instr_pc", instr_pc, 32'd4);
        tick();
        check("load3.instr_pc", instr_pc, 32'd8);
        check("load3.address",  address,  32'd12);

        // Stall for three edges: everything holds
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall.instr",    instr,    32'h8C000002);
            check("stall.instr_pc", instr_pc, 32'd8);
            check("stall.address",  address,  32'd12);
            check_status("stall", 1'b1, 1'b0, 1'b0);
        end
        stall = 1'b0;
        tick();
        check("unstall.instr_pc", instr_pc, 32'd12);
        check("unstall.instr",    instr,    32'h8C000003);
        check("unstall.address",  address,  32'd16);

        // Redirect together with stall: redirect wins, one bubble
        redirect_valid  = 1'b1;
        redirect_target = 32'd120;
        stall           = 1'b1;
        tick();
        redirect_valid  = 1'b0;
        stall           = 1'b0;
        check("redir.address", address, 32'd120);
        check_status("redir", 1'b0, 1'b0, 1'b0);
        tick();
        check("redir.instr_pc", instr_pc, 32'd120);
        check("redir.instr",    instr,    32'h8C00001E);
        check_status("redir_t", 1'b1, 1'b0, 1'b0);

        // Run to the end of the program: 124..356 is 59 more fetches
        for (int k = 0; k < 59; k++) begin
            tick();
        end
        check("last.instr_pc", instr_pc, 32'd356);
        check("last.instr",    instr,    32'h8C000059);
        check("last.address",  address,  32'd360);
        check_status("last", 1'b1, 1'b0, 1'b0);
        tick();
        check("done.address",  address,  32'd360);
        check("done.instr_pc", instr_pc, 32'd356);
        check_status("done", 1'b0, 1'b1, 1'b0);

        // DONE ignores stall; an aligned redirect (even with stall) resumes
        stall = 1'b1;
        tick();
        check("done_hold.address", address, 32'd360);
        check_status("done_hold", 1'b0, 1'b1, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 32'd0;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("resume.address", address, 32'd0);
        check_status("resume", 1'b0, 1'b0, 1'b0);
        tick();
        check("resume.instr_pc", instr_pc, 32'd0);
        check("resume.instr",    instr,    32'h8D100200);
        check_status("resume_f", 1'b1, 1'b0, 1'b0);

        // Misaligned redirect: FAULT, pc unchanged
        redirect_valid  = 1'b1;
        redirect_target = 32'd270;
        tick();
        check("mis.address", address, 32'd4);
        check_status("mis", 1'b0, 1'b1, 1'b1);
        // FAULT ignores an aligned redirect and normal fetch
        redirect_target = 32'd64;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("fault_hold.address", address, 32'd4);
        check_status("fault_hold", 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle, no clock edge in between
        #2;
        reset = 1'b1;
        #1;
        check("areset.address", address, 32'd0);
        check_status("areset", 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        tick();
        check("post_rst.instr_pc", instr_pc, 32'd0);
        check("post_rst.instr",    instr,    32'h8D100200);
        check_status("post_rst", 1'b1, 1'b0, 1'b0);

`ifdef IFETCH_OPCODE_CHECK_EN
        // Illegal opcode at byte 4 sends fetch to FAULT, holding instr/instr_pc
        reset  = 1'b1;
        mem[1] = 32'hFFFFFFFF;
        tick();
        reset = 1'b0;
        tick();
        check("opc0.instr_pc", instr_pc, 32'd0);
        check_status("opc0", 1'b1, 1'b0, 1'b0);
        tick();
        check("opc.instr_pc", instr_pc, 32'd0);
        check("opc.instr",    instr,    32'h8D100200);
        check_status("opc", 1'b0, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage for the MIPS datapath. It owns the program counter and drives the read address of the combinational, byte-addressed instruction memory, where words sit at multiples of 4. Each fetched word is registered together with its PC and handed to decode under a stall/redirect protocol. It stops cleanly at the end of the loaded program and flags illegal redirects.

## Interface
- RESET_PC, 0, PC value loaded on reset.
- PC_LIMIT, 360, first byte address past the program; no fetch occurs at pc >= PC_LIMIT.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- address  output  32  instruction-memory read address; always equals the internal pc.
- data_out  input  32  instruction-memory read data; valid combinationally in the same cycle as address.
- stall  input  1  decode not ready; freeze pc and all outputs.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new pc when redirect_valid is high.
- instr  output  32  registered instruction word.
- instr_pc  output  32  byte address instr was fetched from.
- instr_valid  output  1  instr/instr_pc hold a live instruction.
- halted  output  1  fetch stopped (DONE or FAULT).
- fault  output  1  FAULT state reached.

## Operation
- States:
  - RUN: fetch every non-stalled cycle.
  - DONE: end of program reached.
  - FAULT: sticky until reset.
- Per-edge priority in RUN, highest first:
  1. reset.
  2. redirect_valid.
  3. stall.
  4. fetch.
- Redirect with redirect_target[1:0]==0:
  - pc <= target.
  - instr_valid <= 0 (flushes the in-flight word).
  - Stay in RUN.
- Redirect with redirect_target[1:0]!=0:
  - Go to FAULT; instr_valid <= 0.
  - fault = halted = 1.
  - pc is unchanged.
- Stall (no redirect): pc, instr, instr_pc, instr_valid and state all hold.
- Fetch when pc < PC_LIMIT:
  - instr <= data_out.
  - instr_pc <= pc.
  - instr_valid <= 1.
  - pc <= pc + 4, modulo 2^32 wrap.
- Fetch attempt when pc >= PC_LIMIT:
  - instr_valid <= 0.
  - Go to DONE; halted = 1.
  - pc holds.
- DONE:
  - An aligned redirect returns to RUN with pc <= target and halted = 0.
  - A misaligned redirect goes to FAULT.
  - stall and all other inputs are ignored.
- FAULT ignores all inputs; only reset exits it.
- halted = (state != RUN); fault = (state == FAULT). Both are decoded from registered state.

## Timing
- Reset values:
  - pc = RESET_PC, so address = RESET_PC.
  - instr = 0, instr_pc = 0, instr_valid = 0.
  - state = RUN, halted = 0, fault = 0.
- Fetch latency is 1 cycle: the word at address in cycle N appears on instr after edge N+1.
- Throughput is one instruction per cycle with no stall.
- Redirect costs 1 bubble: instr_valid = 0 for the cycle after the redirect edge. The target word appears one cycle later.
- Asserting reset mid-operation clears everything immediately, without waiting for clk. Deasserting reset gives a fetch at RESET_PC on the next edge.
- A redirect and a stall in the same cycle: the redirect wins and the stall is ignored for that edge.
- The PC_LIMIT comparison is unsigned, 32-bit.

## Configuration
- IFETCH_OPCODE_CHECK_EN defined:
  - Each fetched data_out is checked before capture. Legal words:
    - opcode 100011 (lw).
    - opcode 101011 (sw).
    - opcode 000000 with funct 100000 (add) or 011000 (mul).
  - On any other word: instr_valid <= 0, go to FAULT, instr/instr_pc hold.
- IFETCH_OPCODE_CHECK_EN undefined: no check; every word is delivered; FAULT is reached only via a misaligned redirect.

## Test plan
- Program load:
  - Stimulus: memory[0] = 32'h8D100200, memory[4] = 32'h8D300300; release reset with RESET_PC = 0.
  - Response: after edge 1, instr = 32'h8D100200, instr_pc = 0, instr_valid = 1. After edge 2, instr = 32'h8D300300, instr_pc = 4.
- Stall:
  - Stimulus: assert stall for 3 cycles while instr_pc = 8.
  - Response: instr, instr_pc = 8, address = 12 and instr_valid all hold. Fetch at 12 occurs on the first edge after stall drops.
- Redirect plus stall:
  - Stimulus: redirect_valid = 1, redirect_target = 120, stall = 1 in the same cycle.
  - Response: next cycle address = 120 and instr_valid = 0. The following cycle instr_pc = 120 and instr_valid = 1.
- End of program:
  - Stimulus: run from 0 with no stall.
  - Response: the last valid instruction has instr_pc = 356. The next edge gives instr_valid = 0, halted = 1, address = 360. A redirect to 0 then resumes with halted = 0.
- Misaligned redirect:
  - Stimulus: redirect_target = 270.
  - Response: fault = 1, halted = 1, instr_valid = 0. Inputs are ignored until reset; an async reset mid-cycle clears fault with no clk edge needed.
- With IFETCH_OPCODE_CHECK_EN:
  - Stimulus: memory[4] = 32'hFFFFFFFF.
  - Response: after the fetch edge, instr_valid = 0, fault = 1, instr_pc stays 0.
